// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch-side PC logic.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pcState_e;

  localparam logic [31:0] PC_INC          = 32'd4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic isAligned(input logic [31:0] addr);
    return (addr & ~ADDR_ALIGN_MASK) == 32'd0;
  endfunction

  function automatic logic [31:0] alignAddr(input logic [31:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC priority select (jr > jump > branch > sequential) with alignment check.
module pc_target_mux
  import mips_pkg::*;
#(
  parameter bit FAULT_EN = 1'b1
) (
  input  logic        [31:0] pcPlus4,
  input  logic               jump,
  input  logic        [31:0] jumpTarget,
  input  logic               branchTaken,
  input  logic signed [31:0] branchOffset,
  input  logic               jr,
  input  logic        [31:0] jrTarget,
  output logic        [31:0] nextPc,
  output logic               redirect,
  output logic               misaligned
);

  logic        [31:0] rawTarget;
  logic signed [31:0] branchSum;

  // Branch target wraps modulo 2^32; the signed add makes the offset intent explicit.
  assign branchSum = $signed(pcPlus4) + branchOffset;

  always_comb begin
    rawTarget = pcPlus4;
    if (jr) begin
      rawTarget = jrTarget;
    end else if (jump) begin
      rawTarget = jumpTarget;
    end else if (branchTaken) begin
      rawTarget = $unsigned(branchSum);
    end
  end

  assign redirect = jr | jump | branchTaken;

  // Without fault trapping the low address bits are simply dropped.
  assign misaligned = FAULT_EN && redirect && !isAligned(rawTarget);
  assign nextPc     = FAULT_EN ? rawTarget : alignAddr(rawTarget);

endmodule

// File: rtl/pc_next_unit.sv
// Registered program counter with BOOT/RUN/HALT control, stall hold, flush pulse and misalignment fault.
module pc_next_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit          FAULT_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        flush,
  output logic        fault,
  output logic [31:0] fault_addr
);

  pcState_e    state, stateNext;
  logic [31:0] pcReg, pcNext;
  logic        validReg, validNext;
  logic        flushReg, flushNext;
  logic        faultReg, faultNext;
  logic [31:0] faultAddrReg, faultAddrNext;

  logic [31:0] muxPc;
  logic        muxRedirect;
  logic        muxMisaligned;

  assign pc_plus4 = pcReg + PC_INC;

  pc_target_mux #(
    .FAULT_EN (FAULT_EN)
  ) targetMux (
    .pcPlus4      (pc_plus4),
    .jump         (jump),
    .jumpTarget   (jump_target),
    .branchTaken  (branch_taken),
    .branchOffset ($signed(branch_offset)),
    .jr           (jr),
    .jrTarget     (jr_target),
    .nextPc       (muxPc),
    .redirect     (muxRedirect),
    .misaligned   (muxMisaligned)
  );

  always_comb begin
    stateNext     = state;
    pcNext        = pcReg;
    validNext     = validReg;
    flushNext     = 1'b0;
    faultNext     = faultReg;
    faultAddrNext = faultAddrReg;
    case (state)
      BOOT: begin
        stateNext = RUN;
        validNext = 1'b1;
      end
      RUN: begin
        // Flush only marks the first cycle a redirect target is visible, so a stall drops it.
        if (!stall) begin
          if (muxMisaligned) begin
            stateNext     = HALT;
            validNext     = 1'b0;
            faultNext     = 1'b1;
            faultAddrNext = muxPc;
          end else begin
            pcNext    = muxPc;
            flushNext = muxRedirect;
          end
        end
      end
      HALT: begin
        validNext = 1'b0;
      end
      default: begin
        stateNext = HALT;
        validNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pcReg        <= RESET_VECTOR;
      validReg     <= 1'b0;
      flushReg     <= 1'b0;
      faultReg     <= 1'b0;
      faultAddrReg <= 32'd0;
    end else begin
      state        <= stateNext;
      pcReg        <= pcNext;
      validReg     <= validNext;
      flushReg     <= flushNext;
      faultReg     <= faultNext;
      faultAddrReg <= faultAddrNext;
    end
  end

  assign pc         = pcReg;
  assign pc_valid   = validReg;
  assign flush      = flushReg;
  assign fault      = faultReg;
  assign fault_addr = faultAddrReg;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed scoreboard bench for pc_next_unit; a FAULT_EN=0 copy shares the stimulus.
module tb_pc_next_unit;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jumpTarget = 32'd0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchOffset = 32'd0;
  logic        jr = 1'b0;
  logic [31:0] jrTarget = 32'd0;

  logic [31:0] pc, pcPlus4, faultAddr;
  logic        pcValid, flush, fault;
  logic [31:0] pc2, pcPlus4b, faultAddr2;
  logic        pcValid2, flush2, fault2;

  pc_next_unit #(.RESET_VECTOR(32'h0), .FAULT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .jump(jump), .jump_target(jumpTarget),
    .branch_taken(branchTaken), .branch_offset(branchOffset),
    .jr(jr), .jr_target(jrTarget),
    .pc(pc), .pc_plus4(pcPlus4), .pc_valid(pcValid),
    .flush(flush), .fault(fault), .fault_addr(faultAddr)
  );

  pc_next_unit #(.RESET_VECTOR(32'h0), .FAULT_EN(1'b0)) dutNoFault (
    .clk(clk), .reset(reset), .stall(stall),
    .jump(jump), .jump_target(jumpTarget),
    .branch_taken(branchTaken), .branch_offset(branchOffset),
    .jr(jr), .jr_target(jrTarget),
    .pc(pc2), .pc_plus4(pcPlus4b), .pc_valid(pcValid2),
    .flush(flush2), .fault(fault2), .fault_addr(faultAddr2)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        fault;
    logic [31:0] faultAddr;
    logic [31:0] pc2;
    logic        fault2;
  } expect_t;

  expect_t sbQ[$];
  int checks = 0;
  int errors = 0;
  int stepNo = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL step %0d %s observed %h expected %h", stepNo, tag, got, want);
    end
  endtask

  // Monitor: compare one scoreboard entry shortly after every rising edge.
  always @(posedge clk) begin
    #1;
    if (sbQ.size() > 0) begin
      expect_t e;
      e = sbQ.pop_front();
      stepNo++;
      check("pc", pc, e.pc);
      check("pc_plus4", pcPlus4, e.pc + 32'd4);
      check("pc_valid", {31'd0, pcValid}, {31'd0, e.valid});
      check("flush", {31'd0, flush}, {31'd0, e.flush});
      check("fault", {31'd0, fault}, {31'd0, e.fault});
      check("fault_addr", faultAddr, e.faultAddr);
      check("pc_nofault", pc2, e.pc2);
      check("fault_nofault", {31'd0, fault2}, {31'd0, e.fault2});
    end
  end

  task automatic setIn(input logic rst, input logic stl,
                       input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bo,
                       input logic r, input logic [31:0] rt);
    reset = rst; stall = stl; jump = j; jumpTarget = jt;
    branchTaken = b; branchOffset = bo; jr = r; jrTarget = rt;
  endtask

  // Push what both DUTs must show after the coming edge, then advance one cycle.
  task automatic expectStep(input logic [31:0] ePc, input logic eValid, input logic eFlush,
                            input logic eFault, input logic [31:0] eFaultAddr,
                            input logic [31:0] ePc2, input logic eFault2);
    expect_t e;
    e.pc = ePc; e.valid = eValid; e.flush = eFlush; e.fault = eFault;
    e.faultAddr = eFaultAddr; e.pc2 = ePc2; e.fault2 = eFault2;
    sbQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic same(input logic [31:0] ePc, input logic eValid, input logic eFlush);
    expectStep(ePc, eValid, eFlush, 1'b0, 32'd0, ePc, 1'b0);
  endtask

  initial begin
    // Reset for two cycles, then BOOT and sequential run.
    setIn(1, 0, 0, 0, 0, 0, 0, 0);
    same(32'h0, 0, 0);
    same(32'h0, 0, 0);
    setIn(0, 1, 1, 32'h40, 0, 0, 0, 0);
    same(32'h0, 1, 0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    same(32'h4, 1, 0);
    same(32'h8, 1, 0);
    same(32'hC, 1, 0);

    // Jumps from the concatenator, back to back.
    setIn(0, 0, 1, 32'hFFFF_8000, 0, 0, 0, 0);
    same(32'hFFFF_8000, 1, 1);
    setIn(0, 0, 1, 32'hFFFF_8FF0, 0, 0, 0, 0);
    same(32'hFFFF_8FF0, 1, 1);
    setIn(0, 0, 1, 32'hAFFF_8000, 0, 0, 0, 0);
    same(32'hAFFF_8000, 1, 1);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    same(32'hAFFF_8004, 1, 0);

    // Negative branch offset, then jr beating branch and jump.
    setIn(0, 0, 1, 32'h100, 0, 0, 0, 0);
    same(32'h100, 1, 1);
    setIn(0, 0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0);
    same(32'hF4, 1, 1);
    setIn(0, 0, 1, 32'h100, 0, 0, 0, 0);
    same(32'h100, 1, 1);
    setIn(0, 0, 1, 32'h800, 1, 32'hFFFF_FFF0, 1, 32'h400);
    same(32'h400, 1, 1);
    setIn(0, 0, 1, 32'h800, 1, 32'h10, 0, 0);
    same(32'h800, 1, 1);

    // Stall holds pc with a pending jump; flush only after release.
    setIn(0, 0, 1, 32'h20, 0, 0, 0, 0);
    same(32'h20, 1, 1);
    setIn(0, 1, 1, 32'h80, 0, 0, 0, 0);
    same(32'h20, 1, 0);
    same(32'h20, 1, 0);
    same(32'h20, 1, 0);
    setIn(0, 0, 1, 32'h80, 0, 0, 0, 0);
    same(32'h80, 1, 1);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    same(32'h84, 1, 0);

    // Sequential wrap at the top of the address space.
    setIn(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    same(32'hFFFF_FFFC, 1, 1);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    same(32'h0, 1, 0);
    same(32'h4, 1, 0);

    // Misaligned jr: trapping copy halts, the other masks the low bits.
    setIn(0, 0, 0, 0, 0, 0, 1, 32'h1002);
    expectStep(32'h4, 0, 0, 1, 32'h1002, 32'h1000, 0);
    setIn(0, 0, 0, 0, 0, 0, 1, 32'h13);
    expectStep(32'h4, 0, 0, 1, 32'h1002, 32'h10, 0);
    setIn(0, 0, 1, 32'h200, 0, 0, 0, 0);
    expectStep(32'h4, 0, 0, 1, 32'h1002, 32'h200, 0);
    setIn(0, 1, 0, 0, 1, 32'h8, 0, 0);
    expectStep(32'h4, 0, 0, 1, 32'h1002, 32'h200, 0);

    // Reset exits HALT, then normal operation resumes.
    setIn(1, 1, 1, 32'h300, 0, 0, 0, 0);
    same(32'h0, 0, 0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    same(32'h0, 1, 0);
    setIn(0, 0, 0, 0, 1, 32'h8, 0, 0);
    same(32'hC, 1, 1);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    same(32'h10, 1, 0);

    // Reset during a stall.
    setIn(1, 1, 1, 32'h500, 0, 0, 0, 0);
    same(32'h0, 0, 0);

    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    assert (sbQ.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Registered program counter with next-PC selection for the single-cycle MIPS datapath.
- Sits directly downstream of the jump-address concatenator: consumes its 32-bit jump target, the branch offset path and the jr register path, and updates the PC each clock.
- Also feeds the concatenator its upper-bits source (pc_plus4).
- Adds stall hold, a one-cycle flush pulse on redirect, and a sticky misaligned-target fault.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- FAULT_EN, 1, 1 = misaligned targets trap into HALT; 0 = bits [1:0] of targets are forced to 00 and no fault is raised.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle; redirect requests are not sampled while high.
- jump  in  1  select jump_target.
- jump_target  in  32  concatenated target {pc_plus4[31:28], instr_index<<2} from the concatenator.
- branch_taken  in  1  select branch target.
- branch_offset  in  32  sign-extended immediate, already shifted left 2.
- jr  in  1  select jr_target (register jump).
- jr_target  in  32  register value for jr/jalr.
- pc  out  32  current PC, registered.
- pc_plus4  out  32  pc + 4, combinational from the pc register; drives the concatenator's PC input.
- pc_valid  out  1  pc holds a fetchable address.
- flush  out  1  one-cycle pulse after a taken redirect.
- fault  out  1  sticky misaligned-target flag.
- fault_addr  out  32  offending target captured at fault.

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high, sampled on the rising edge.
- Reset values: pc=RESET_VECTOR, pc_valid=0, flush=0, fault=0, fault_addr=0, state=BOOT.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after reset deasserts; pc holds RESET_VECTOR, pc_valid=0.
  - Next state is RUN; pc_valid=1 from the RUN cycle on.
  - Inputs are ignored in BOOT.
- RUN, stall=0: next pc selected by fixed priority:
  - jr → jr_target
  - jump → jump_target
  - branch_taken → pc_plus4 + branch_offset (32-bit modulo, wrap silently)
  - otherwise → pc_plus4 (0xFFFF_FFFC + 4 wraps to 0x0000_0000)
- RUN, stall=1: pc, flush and all state held; jr/jump/branch_taken ignored. Upstream keeps them asserted until stall drops.
- Latency: the selected target appears on pc one cycle after the sampling edge.
- flush:
  - =1 for exactly the one cycle in which pc first shows a redirect (jr, jump or branch) target.
  - =0 otherwise, including after sequential updates and stalled cycles.
  - Back-to-back redirects give consecutive flush cycles.
- Misalignment (FAULT_EN=1): if the selected redirect target has bits [1:0] ≠ 00:
  - pc is not updated and state goes to HALT.
  - fault=1 and fault_addr=target, both on the next edge.
  - pc_valid=0 and flush=0 in HALT.
- HALT: all outputs frozen; only reset exits.
- FAULT_EN=0: targets masked with ~32'h3 and no fault is raised.
- Reset mid-operation, including in HALT or during stall, wins over everything and returns to the reset values.
- Simultaneous selects: resolved by the priority above; no error for multiple selects.

Decomposition:
- Shared package mips_pkg:
  - state enum {BOOT, RUN, HALT}
  - constant PC_INC = 32'd4
  - constant ADDR_ALIGN_MASK = 32'hFFFF_FFFC
- One natural sub-module: pc_target_mux. Purely combinational: priority select plus alignment check, outputs next_pc, redirect, misaligned.
- The FSM and registers stay in pc_next_unit.

Test Plan:
- Reset then sequential run: reset 2 cycles, release.
  - pc=0x0 and pc_valid=0 for the BOOT cycle, then pc_valid=1.
  - Sequence then runs 0x0, 0x4, 0x8, 0xC; flush stays 0.
- Jump from concatenator: pc=0xFFFF_8000, jump=1, jump_target=0xFFFF_8000|0x0FF0 → 0xFFFF_8FF0, flush=1 for one cycle. Then jump_target=0xAFFF_8000 → pc=0xAFFF_8000 next cycle, flush=1 again.
- Branch with negative offset and priority: pc=0x100, branch_taken=1, branch_offset=0xFFFF_FFF0 → pc=0xF4.
  - Same cycle with jr=1 and jr_target=0x400 → pc=0x400 (jr wins).
- Stall: pc=0x20, stall=1 for 3 cycles with jump=1 and jump_target=0x80 → pc stays 0x20 and flush=0.
  - stall=0 → pc=0x80 next cycle, flush=1.
- Fault: jr=1, jr_target=0x1002 → fault=1, fault_addr=0x1002, pc unchanged, pc_valid=0.
  - Further inputs have no effect; reset clears to pc=0x0 and fault=0.
- Wrap: pc=0xFFFF_FFFC sequential → pc=0x0; with FAULT_EN=0, jr_target=0x13 → pc=0x10 and fault stays 0.
